// File: rtl/disp_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment display controller.
//   NUM_DIGITS   : number of scanned digits
//   SEG_*        : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   slot_state_t : per-slot phase (blanking dead-time vs. digit on)
package disp_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the display controller and its user.
//   load/digits/lz_en                 : value capture and leading-zero control
//   transistor/d7sp/busy/frame_tick   : pin drives and status
// master = user side, slave = controller side.
interface display_scan_ctrl_if;
    logic        load;
    logic [11:0] digits;
    logic        lz_en;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic        busy;
    logic        frame_tick;

    modport master (
        output load, digits, lz_en,
        input  transistor, d7sp, busy, frame_tick
    );

    modport slave (
        input  load, digits, lz_en,
        output transistor, d7sp, busy, frame_tick
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder.
//   code : 4-bit digit code
//   seg  : active-high {g,f,e,d,c,b,a}; codes 10..15 show a dash
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 3-digit 7-segment display.
// Scans units -> tens -> hundreds, SCAN_DIV cycles per digit, the first DEAD
// cycles of each slot blanked. New values are latched into a pending buffer
// and only promoted to the displayed value at the frame boundary.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of display_scan_ctrl_if (load/digits/lz_en in,
//              transistor/d7sp/busy/frame_tick out, all outputs registered)
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int DEAD     = 4
) (
    input logic                clk,
    input logic                rst,
    display_scan_ctrl_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam slot_state_t ST_RESET = (DEAD > 0) ? ST_BLANK : ST_ON;

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;
    logic [11:0]      active, pending;
    logic             pending_valid;
    slot_state_t      state, state_n;

    logic             cnt_last, boundary;
    logic [3:0]       code;
    logic [6:0]       seg;
    logic             lz_blank;
    logic [2:0]       transistor_n;
    logic [6:0]       d7sp_n;

    assign cnt_last = (cnt == CNT_W'(SCAN_DIV - 1));
    assign boundary = cnt_last && (idx == 2'd2);
    assign cnt_n    = cnt_last ? '0 : cnt + CNT_W'(1);
    assign idx_n    = !cnt_last ? idx : (idx == 2'd2) ? 2'd0 : idx + 2'd1;

    bcd_to_7seg u_dec (
        .code (code),
        .seg  (seg)
    );

    // state tracks the phase of the current cnt value, so it is computed
    // from the count the slot counter is about to take.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RESET;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = (int'(cnt_n) < DEAD) ? ST_BLANK : ST_ON;
        code         = active[3:0];
        lz_blank     = 1'b0;
        transistor_n = 3'b000;
        d7sp_n       = SEG_BLANK;
        case (idx)
            2'd1:    code = active[7:4];
            2'd2:    code = active[11:8];
            default: code = active[3:0];
        endcase
        // Suppress leading zeros from the hundreds digit downward; units always shown.
        if (bus.lz_en) begin
            if (idx == 2'd2)
                lz_blank = (active[11:8] == 4'd0);
            else if (idx == 2'd1)
                lz_blank = (active[11:8] == 4'd0) && (active[7:4] == 4'd0);
        end
        if (state == ST_ON) begin
            transistor_n = 3'(1) << idx;
            d7sp_n       = lz_blank ? SEG_BLANK : seg;
        end
    end

    // Scan position and value buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            cnt <= cnt_n;
            idx <= idx_n;
            if (boundary) begin
                // A load landing on the boundary bypasses the pending buffer.
                if (bus.load)           active <= bus.digits;
                else if (pending_valid) active <= pending;
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pending       <= bus.digits;
                pending_valid <= 1'b1;
            end
        end
    end

    // Registered pin drives; frame_tick lands in the first cycle of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.transistor <= '0;
            bus.d7sp       <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.transistor <= transistor_n;
            bus.d7sp       <= d7sp_n;
            bus.frame_tick <= boundary;
        end
    end

    assign bus.busy = pending_valid;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
    localparam int SD    = 8;
    localparam int DT    = 2;
    localparam int FRAME = 3 * SD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: displayed value, buffered value, and edges since reset.
    logic [11:0] m_active, m_pend;
    logic        m_pv;
    int          ecount;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, ecount, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare all outputs.
    task automatic tick(input logic r, input logic ld, input logic [11:0] dg);
        int p, slot, off;
        logic [3:0] h, t, c;
        logic blank;
        logic [2:0] e_tr;
        logic [6:0] e_seg;
        logic e_tick, e_busy;
        rst        = r;
        bus.load   = ld;
        bus.digits = dg;
        p    = ecount;
        slot = (p / SD) % 3;
        off  = p % SD;
        h = m_active[11:8];
        t = m_active[7:4];
        c = m_active[slot*4 +: 4];
        blank = bus.lz_en && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0));
        e_tr   = (off >= DT) ? 3'(1 << slot) : 3'b000;
        e_seg  = (off >= DT && !blank) ? ref_seg(c) : 7'b0;
        e_tick = (p % FRAME == FRAME - 1);
        if (r) begin
            e_tr = 0; e_seg = 0; e_tick = 0;
            m_active = 0; m_pend = 0; m_pv = 0;
        end else if (p % FRAME == FRAME - 1) begin
            if (ld)        m_active = dg;
            else if (m_pv) m_active = m_pend;
            m_pv = 0;
        end else if (ld) begin
            m_pend = dg;
            m_pv   = 1;
        end
        e_busy = m_pv;
        @(posedge clk);
        #1;
        ecount = r ? 0 : ecount + 1;
        chk("transistor", 12'(bus.transistor), 12'(e_tr));
        chk("d7sp", 12'(bus.d7sp), 12'(e_seg));
        chk("frame_tick", 12'(bus.frame_tick), 12'(e_tick));
        chk("busy", 12'(bus.busy), 12'(e_busy));
        bus.load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 12'h000);
    endtask

    task automatic to_boundary();
        while (ecount % FRAME != FRAME - 1) tick(1'b0, 1'b0, 12'h000);
    endtask

    int ft_count;

    initial begin
        rst = 1'b1; bus.load = 1'b0; bus.digits = 12'h000; bus.lz_en = 1'b0;
        m_active = 0; m_pend = 0; m_pv = 0; ecount = 0;

        // reset state
        tick(1'b1, 1'b0, 12'h000);
        tick(1'b1, 1'b0, 12'h000);

        // 0x123 displayed from the next frame
        tick(1'b0, 1'b1, 12'h123);
        run(2 * FRAME + 5);

        // two loads in one frame: last wins; count frame_tick pulses
        tick(1'b0, 1'b1, 12'h045);
        run(3);
        tick(1'b0, 1'b1, 12'h678);
        ft_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 12'h000);
            if (bus.frame_tick) ft_count++;
        end
        chk("frame_tick_count", 12'(ft_count), 12'd2);

        // load exactly on the boundary cycle
        to_boundary();
        tick(1'b0, 1'b1, 12'h999);
        chk("busy_after_boundary_load", 12'(bus.busy), 12'd0);
        run(FRAME + 4);

        // leading-zero suppression
        bus.lz_en = 1'b1;
        tick(1'b0, 1'b1, 12'h007);
        run(2 * FRAME);
        tick(1'b0, 1'b1, 12'h070);
        run(2 * FRAME);
        bus.lz_en = 1'b0;

        // dash for code 0xA in tens
        tick(1'b0, 1'b1, 12'h0A5);
        run(2 * FRAME);

        // reset mid-frame with a load pending
        run(5);
        tick(1'b0, 1'b1, 12'h456);
        run(2);
        tick(1'b1, 1'b0, 12'h000);
        run(FRAME + 3);

        // randomized traffic, including non-BCD codes
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(39) == 0) bus.lz_en = ~bus.lz_en;
            if ($urandom_range(15) == 0)
                tick(1'b0, 1'b1, 12'($urandom));
            else
                tick(1'b0, 1'b0, 12'h000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the three-digit 7-segment display driven from the top-level wrapper. It holds a 3-digit BCD value and scans the digits round-robin on the shared segment bus. It inserts blanking dead-time between digits to prevent ghosting and applies new values only at frame boundaries, so the display never tears. Its outputs connect directly to the digit-select transistor pins and the segment pins.

## Interface

Parameters:
- SCAN_DIV, 1024: clock cycles per digit slot; must be at least DEAD + 1.
- DEAD, 4: blanked cycles at the start of each slot; may be 0.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- load, input, 1: single-cycle strobe that captures digits.
- digits, input, 12: BCD value as {hundreds[11:8], tens[7:4], units[3:0]}.
- lz_en, input, 1: enables leading-zero suppression; sampled continuously.
- transistor, output, 3: one-hot digit select, active-high; bit 0 = units, bit 2 = hundreds.
- d7sp, output, 7: segments {g,f,e,d,c,b,a}, active-high.
- busy, output, 1: high while a captured value awaits the frame boundary.
- frame_tick, output, 1: one-cycle pulse when a new frame begins.

## Operation

- Slot counter cnt runs 0..SCAN_DIV-1. Digit index idx runs 0→1→2→0 and advances when cnt wraps.
- Per-slot state machine:
  - BLANK while cnt < DEAD: transistor = 000, d7sp = 0000000.
  - ON otherwise: transistor = one-hot(idx), d7sp = decode of active[idx].
- Frame boundary: the cycle in which cnt = SCAN_DIV-1 and idx = 2.
  - At the boundary, if pending_valid: active ← pending, pending_valid ← 0.
  - frame_tick is high in the first cycle of the following frame (idx = 0, cnt = 0), whether or not an update occurred.
- Load:
  - load = 1 writes digits into pending and sets pending_valid.
  - A second load before the boundary overwrites pending; last value wins.
  - If load coincides with the boundary cycle, the loaded digits go straight into active for the next frame, and pending_valid ends at 0.
- busy = pending_valid.
- Decode:
  - 0–9 use standard patterns: 0 = 0111111, 1 = 0000110, 8 = 1111111.
  - Codes 10–15 display a dash, 1000000.
- Leading-zero suppression (lz_en = 1):
  - Hundreds digit is blanked (d7sp = 0 during its ON phase) if it is 0.
  - Tens digit is blanked if hundreds = 0 and tens = 0.
  - Units digit is never blanked.
  - While a digit is blanked, transistor still asserts during its ON phase.
- Reset: cnt = 0, idx = 0, active = 000, pending = 000, pending_valid = 0.
  - All outputs are 0 during reset and in the cycle after it.
  - Reset mid-frame discards pending and active values.

## Timing

- All outputs are registered and reflect the cnt/idx value of the previous cycle. Outputs first become non-zero at cycle DEAD+1 after rst falls, counting rst-low edges.
- Slot length is exactly SCAN_DIV cycles; frame length is exactly 3·SCAN_DIV cycles; ON phase is SCAN_DIV − DEAD cycles.
- transistor never has more than one bit set. It changes only through the 000 state when DEAD ≥ 1.
- Load-to-display latency is at most 3·SCAN_DIV + 1 cycles. No input handshake stalls: load is always accepted.
- lz_en changes take effect on the next output cycle.

## Structure

- Package disp_pkg holds:
  - NUM_DIGITS = 3.
  - Segment pattern constants for 0–9, dash, and blank.
  - The BLANK/ON state enum.
- Sub-module bcd_to_7seg: a 4-bit code in, 7-bit pattern out (dash for codes 10–15). It is purely combinational and instantiated once on the muxed digit.
- The counter, digit index, pending/active registers and output registers live in display_scan_ctrl.

## Test plan

All scenarios use SCAN_DIV = 8, DEAD = 2.

- Reset release, then load digits = 0x123 → one frame later transistor cycles 001/010/100. Each select is high 6 cycles and low 2 between slots; d7sp shows 3, 2, 1 for units, tens, hundreds.
- Load 0x045 then 0x678 within the same frame → next frame shows 678. busy falls at the boundary. frame_tick pulses once every 24 cycles.
- load asserted exactly on the boundary cycle with 0x999 → the following frame shows 999; busy is never observed high.
- lz_en = 1 with 0x007 → hundreds and tens ON phases have d7sp = 0 with transistor still asserted; units shows 0000111. 0x070 → only the hundreds digit is blanked.
- Digit code 0xA in the tens position → d7sp = 1000000 during the tens ON phase.
- Assert rst mid-frame with a load pending → outputs are 0 the next cycle. After release, the display shows blank 000 patterns (0111111, no lz), and busy = 0.
